// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU-op encodings and the main-control bundle.
package riscv_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  // Encodings consumed by the EX-stage ALU-control decoder
  localparam logic [1:0] ALUOP_LW_SW = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_R     = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/main_decoder.sv
// Combinational RV32 main decoder: opcode to control bundle, immediate and register fields.
module main_decoder
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [INST_W-1:0] i_inst,
  output ctrl_t             o_ctrl,
  output logic [XLEN-1:0]   o_imm,
  output logic              o_uses_rs2,
  output logic              o_legal,
  output logic [REG_AW-1:0] o_rs1,
  output logic [REG_AW-1:0] o_rs2,
  output logic [REG_AW-1:0] o_rd,
  output logic [2:0]        o_funct3,
  output logic              o_inst_30
);

  logic [OPCODE_W-1:0] w_opcode;
  logic [XLEN-1:0]     w_imm_i;
  logic [XLEN-1:0]     w_imm_s;
  logic [XLEN-1:0]     w_imm_b;

  assign w_opcode  = i_inst[6:0];
  assign o_rs1     = i_inst[19:15];
  assign o_rs2     = i_inst[24:20];
  assign o_rd      = i_inst[11:7];
  assign o_funct3  = i_inst[14:12];
  assign o_inst_30 = i_inst[30];

  assign w_imm_i = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                    i_inst[11:8], 1'b0};

  // Illegal opcodes fall through with an all-zero control bundle
  always_comb begin
    o_ctrl     = CTRL_BUBBLE;
    o_imm      = '0;
    o_uses_rs2 = 1'b0;
    o_legal    = 1'b0;
    case (w_opcode)
      OP_R: begin
        o_ctrl.alu_op    = ALUOP_R;
        o_ctrl.reg_write = 1'b1;
        o_uses_rs2       = 1'b1;
        o_legal          = 1'b1;
      end
      OP_LOAD: begin
        o_ctrl.alu_op     = ALUOP_LW_SW;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_imm             = w_imm_i;
        o_legal           = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.alu_op    = ALUOP_LW_SW;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_imm            = w_imm_s;
        o_uses_rs2       = 1'b1;
        o_legal          = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.alu_op = ALUOP_BEQ;
        o_ctrl.branch = 1'b1;
        o_imm         = w_imm_b;
        o_uses_rs2    = 1'b1;
        o_legal       = 1'b1;
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID-stage control generation, load-use hazard detection and the ID/EX pipeline register.
module id_ex_ctrl_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_id_valid,
  input  logic [INST_W-1:0] if_id_inst,
  input  logic [XLEN-1:0]   if_id_pc,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              if_id_stall,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic              ex_inst_30,
  output logic [2:0]        ex_inst_14_12,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic              id_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t             w_ctrl;
  logic [XLEN-1:0]   w_imm;
  logic              w_uses_rs2;
  logic              w_legal;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd;
  logic [2:0]        w_funct3;
  logic              w_inst_30;
  logic              w_issue;
  logic              w_rd_match;
  logic              w_load_use;

  ctrl_t             r_ctrl;
  logic              r_valid;
  logic              r_inst_30;
  logic [2:0]        r_funct3;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_imm;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_stall_cnt;

  main_decoder #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_main_decoder (
    .i_inst     (if_id_inst),
    .o_ctrl     (w_ctrl),
    .o_imm      (w_imm),
    .o_uses_rs2 (w_uses_rs2),
    .o_legal    (w_legal),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rd       (w_rd),
    .o_funct3   (w_funct3),
    .o_inst_30  (w_inst_30)
  );

  assign w_issue = if_id_valid & w_legal;

  // A load in EX whose destination feeds the instruction now in ID forces one bubble
  assign w_rd_match = (r_rd == w_rs1) | (w_uses_rs2 & (r_rd == w_rs2));
  assign w_load_use = r_valid & r_ctrl.mem_read & (r_rd != '0) & w_issue & w_rd_match;

  assign if_id_stall = ~flush & (ex_hold | w_load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl      <= CTRL_BUBBLE;
      r_valid     <= 1'b0;
      r_inst_30   <= 1'b0;
      r_funct3    <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_illegal <= 1'b0;
      if (flush) begin
        r_valid <= 1'b0;
        r_ctrl  <= CTRL_BUBBLE;
      end else if (!ex_hold) begin
        if (w_load_use) begin
          r_valid <= 1'b0;
          r_ctrl  <= CTRL_BUBBLE;
          if (r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
          end
        end else begin
          r_valid   <= w_issue;
          r_ctrl    <= w_issue ? w_ctrl : CTRL_BUBBLE;
          r_inst_30 <= w_inst_30;
          r_funct3  <= w_funct3;
          r_rs1     <= w_rs1;
          r_rs2     <= w_rs2;
          r_rd      <= w_rd;
          r_pc      <= if_id_pc;
          r_imm     <= w_imm;
          r_illegal <= if_id_valid & ~w_legal;
        end
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_branch     = r_ctrl.branch;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_inst_30    = r_inst_30;
  assign ex_inst_14_12 = r_funct3;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_pc         = r_pc;
  assign ex_imm        = r_imm;
  assign id_illegal    = r_illegal;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed self-checking bench for id_ex_ctrl_stage.
module tb_id_ex_ctrl_stage;

  logic        clk;
  logic        rst_n;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        ex_hold;
  logic        flush;
  logic        if_id_stall;
  logic        ex_valid;
  logic [1:0]  ex_alu_op;
  logic        ex_inst_30;
  logic [2:0]  ex_inst_14_12;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_mem_to_reg;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        id_illegal;
  logic [15:0] stall_cnt;

  int checks;
  int errors;

  id_ex_ctrl_stage #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_id_valid   (if_id_valid),
    .if_id_inst    (if_id_inst),
    .if_id_pc      (if_id_pc),
    .ex_hold       (ex_hold),
    .flush         (flush),
    .if_id_stall   (if_id_stall),
    .ex_valid      (ex_valid),
    .ex_alu_op     (ex_alu_op),
    .ex_inst_30    (ex_inst_30),
    .ex_inst_14_12 (ex_inst_14_12),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_branch     (ex_branch),
    .ex_alu_src    (ex_alu_src),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .id_illegal    (id_illegal),
    .stall_cnt     (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    if_id_valid = v;
    if_id_inst  = inst;
    if_id_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", ex_valid); end
    checks++; if (ex_alu_op !== 2'b00) begin errors++; $display("FAIL reset_alu_op: got %0h want 0", ex_alu_op); end
    checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %0h want 0", ex_reg_write); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0h want 0", stall_cnt); end
    checks++; if (id_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0h want 0", id_illegal); end
    checks++; if (ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h want 0", ex_pc); end
    checks++; if (if_id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", if_id_stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_r_type();
    drive(1'b1, 32'h002081B3, 32'h100); // add x3,x1,x2
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0h want 1", ex_valid); end
    checks++; if (ex_alu_op !== 2'b10) begin errors++; $display("FAIL add_alu_op: got %0h want 2", ex_alu_op); end
    checks++; if (ex_inst_30 !== 1'b0) begin errors++; $display("FAIL add_inst30: got %0h want 0", ex_inst_30); end
    checks++; if (ex_inst_14_12 !== 3'b000) begin errors++; $display("FAIL add_funct3: got %0h want 0", ex_inst_14_12); end
    checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL add_rd: got %0d want 3", ex_rd); end
    checks++; if (ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2) begin errors++; $display("FAIL add_rs: got %0d/%0d want 1/2", ex_rs1, ex_rs2); end
    checks++; if (ex_reg_write !== 1'b1 || ex_alu_src !== 1'b0) begin errors++; $display("FAIL add_ctrl: got rw=%0h src=%0h want 1/0", ex_reg_write, ex_alu_src); end
    checks++; if (ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0 || ex_branch !== 1'b0 || ex_mem_to_reg !== 1'b0) begin
      errors++; $display("FAIL add_other_ctrl: got mr=%0h mw=%0h br=%0h m2r=%0h want 0", ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg);
    end
    checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL add_pc: got %0h want 100", ex_pc); end
    drive(1'b1, 32'h402081B3, 32'h104); // sub x3,x1,x2
    tick();
    checks++; if (ex_inst_30 !== 1'b1) begin errors++; $display("FAIL sub_inst30: got %0h want 1", ex_inst_30); end
    checks++; if (ex_alu_op !== 2'b10) begin errors++; $display("FAIL sub_alu_op: got %0h want 2", ex_alu_op); end
    checks++; if (ex_pc !== 32'h104) begin errors++; $display("FAIL sub_pc: got %0h want 104", ex_pc); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h0080A283, 32'h108); // lw x5,8(x1)
    tick();
    checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("FAIL lw_mem_read: got %0h want 1", ex_mem_read); end
    checks++; if (ex_imm !== 32'd8) begin errors++; $display("FAIL lw_imm: got %0h want 8", ex_imm); end
    checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL lw_rd: got %0d want 5", ex_rd); end
    checks++; if (ex_alu_src !== 1'b1 || ex_mem_to_reg !== 1'b1 || ex_reg_write !== 1'b1 || ex_alu_op !== 2'b00) begin
      errors++; $display("FAIL lw_ctrl: got src=%0h m2r=%0h rw=%0h op=%0h want 1/1/1/0", ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_alu_op);
    end
    drive(1'b1, 32'h00228333, 32'h10C); // add x6,x5,x2
    #1;
    checks++; if (if_id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0h want 1", if_id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got v=%0h mr=%0h rw=%0h want 0", ex_valid, ex_mem_read, ex_reg_write);
    end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    checks++; if (if_id_stall !== 1'b0) begin errors++; $display("FAIL lu_selfclear: got %0h want 0", if_id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6) begin
      errors++; $display("FAIL lu_add_issue: got v=%0h rs1=%0d rd=%0d want 1/5/6", ex_valid, ex_rs1, ex_rd);
    end
    checks++; if (ex_pc !== 32'h10C) begin errors++; $display("FAIL lu_add_pc: got %0h want 10c", ex_pc); end
  endtask

  task automatic test_no_stall_cases();
    drive(1'b1, 32'h0080A003, 32'h200); // lw x0,8(x1)
    tick();
    drive(1'b1, 32'h00200333, 32'h204); // add x6,x0,x2
    #1;
    checks++; if (if_id_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0h want 0", if_id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin errors++; $display("FAIL x0_issue: got v=%0h rd=%0d want 1/6", ex_valid, ex_rd); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL x0_cnt: got %0d want 1", stall_cnt); end
    // lw x5 then lw x6,5(x1): inst[24:20]==5 but loads do not read rs2
    drive(1'b1, 32'h0080A283, 32'h208);
    tick();
    drive(1'b1, 32'h0050A303, 32'h20C);
    #1;
    checks++; if (if_id_stall !== 1'b0) begin errors++; $display("FAIL nors2_stall: got %0h want 0", if_id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'd5 || ex_rd !== 5'd6) begin
      errors++; $display("FAIL nors2_issue: got v=%0h imm=%0h rd=%0d want 1/5/6", ex_valid, ex_imm, ex_rd);
    end
  endtask

  task automatic test_rs2_hazard();
    drive(1'b1, 32'h0080A283, 32'h300); // lw x5,8(x1)
    tick();
    drive(1'b1, 32'h0050A023, 32'h304); // sw x5,0(x1)
    #1;
    checks++; if (if_id_stall !== 1'b1) begin errors++; $display("FAIL rs2_stall: got %0h want 1", if_id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd2) begin errors++; $display("FAIL rs2_bubble: got v=%0h cnt=%0d want 0/2", ex_valid, stall_cnt); end
    tick();
    checks++; if (ex_mem_write !== 1'b1 || ex_rs2 !== 5'd5 || ex_imm !== 32'd0) begin
      errors++; $display("FAIL rs2_sw_issue: got mw=%0h rs2=%0d imm=%0h want 1/5/0", ex_mem_write, ex_rs2, ex_imm);
    end
  endtask

  task automatic test_store_branch();
    drive(1'b1, 32'h0020A623, 32'h400); // sw x2,12(x1)
    tick();
    checks++; if (ex_mem_write !== 1'b1 || ex_alu_src !== 1'b1 || ex_reg_write !== 1'b0 || ex_alu_op !== 2'b00) begin
      errors++; $display("FAIL sw_ctrl: got mw=%0h src=%0h rw=%0h op=%0h want 1/1/0/0", ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op);
    end
    checks++; if (ex_imm !== 32'd12) begin errors++; $display("FAIL sw_imm: got %0h want c", ex_imm); end
    checks++; if (ex_inst_14_12 !== 3'b010) begin errors++; $display("FAIL sw_funct3: got %0h want 2", ex_inst_14_12); end
    drive(1'b1, 32'hFE208CE3, 32'h404); // beq x1,x2,-8
    tick();
    checks++; if (ex_branch !== 1'b1 || ex_alu_op !== 2'b01 || ex_reg_write !== 1'b0 || ex_alu_src !== 1'b0) begin
      errors++; $display("FAIL beq_ctrl: got br=%0h op=%0h rw=%0h src=%0h want 1/1/0/0", ex_branch, ex_alu_op, ex_reg_write, ex_alu_src);
    end
    checks++; if (ex_imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_imm: got %0h want fffffff8", ex_imm); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h00000013, 32'h500);
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_branch !== 1'b0) begin
      errors++; $display("FAIL ill_bubble: got v=%0h rw=%0h br=%0h want 0", ex_valid, ex_reg_write, ex_branch);
    end
    checks++; if (id_illegal !== 1'b1) begin errors++; $display("FAIL ill_pulse: got %0h want 1", id_illegal); end
    drive(1'b0, 32'h002081B3, 32'h504); // legal opcode but not valid
    tick();
    checks++; if (id_illegal !== 1'b0) begin errors++; $display("FAIL ill_clear: got %0h want 0", id_illegal); end
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL invalid_bubble: got v=%0h rw=%0h want 0", ex_valid, ex_reg_write); end
  endtask

  task automatic test_hold();
    drive(1'b1, 32'h002081B3, 32'h600);
    tick();
    drive(1'b1, 32'h402081B3, 32'h604);
    ex_hold = 1'b1;
    #1;
    checks++; if (if_id_stall !== 1'b1) begin errors++; $display("FAIL hold_stall: got %0h want 1", if_id_stall); end
    tick(); tick();
    checks++; if (ex_inst_30 !== 1'b0 || ex_valid !== 1'b1 || ex_pc !== 32'h600) begin
      errors++; $display("FAIL hold_keep: got i30=%0h v=%0h pc=%0h want 0/1/600", ex_inst_30, ex_valid, ex_pc);
    end
    ex_hold = 1'b0;
    tick();
    checks++; if (ex_inst_30 !== 1'b1 || ex_pc !== 32'h604) begin errors++; $display("FAIL hold_release: got i30=%0h pc=%0h want 1/604", ex_inst_30, ex_pc); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0080A283, 32'h700);
    tick();
    drive(1'b1, 32'h00228333, 32'h704);
    flush = 1'b1; ex_hold = 1'b1;
    #1;
    checks++; if (if_id_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0h want 0", if_id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got v=%0h mr=%0h rw=%0h want 0", ex_valid, ex_mem_read, ex_reg_write);
    end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt: got %0d want 2", stall_cnt); end
    flush = 1'b0; ex_hold = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h0080A283, 32'h800);
    tick();
    drive(1'b1, 32'h00228333, 32'h804);
    #1;
    checks++; if (if_id_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %0h want 1", if_id_stall); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_pc !== 32'h0) begin
      errors++; $display("FAIL rst_async: got v=%0h mr=%0h pc=%0h want 0", ex_valid, ex_mem_read, ex_pc);
    end
    checks++; if (if_id_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0h want 0", if_id_stall); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_resume: got v=%0h rd=%0d cnt=%0d want 1/6/0", ex_valid, ex_rd, stall_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_r_type();
    test_load_use();
    test_no_stall_cases();
    test_rs2_hazard();
    test_store_branch();
    test_illegal();
    test_hold();
    test_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
